// File: rtl/md_unit_pkg.sv
// Shared definitions for md_unit: op encodings, latency limit, FSM states
// and the op-class helper. Optional accumulate ops exist only when
// MD_MADD_EN is defined. They need ten encodings, so md_op widens to 4 bits
// in that build and stays at 3 bits otherwise.
package md_unit_pkg;

    // Largest legal MULT_LAT / DIV_LAT; the counter is sized to hold it.
    localparam int MD_LAT_MAX = 15;
    localparam int MD_CNT_W   = 4;

`ifdef MD_MADD_EN
    localparam int MD_OP_W = 4;
`else
    localparam int MD_OP_W = 3;
`endif

    typedef logic [MD_OP_W-1:0]  md_op_t;
    typedef logic [MD_CNT_W-1:0] md_cnt_t;

    localparam md_op_t MD_MULT  = md_op_t'(0);
    localparam md_op_t MD_MULTU = md_op_t'(1);
    localparam md_op_t MD_DIV   = md_op_t'(2);
    localparam md_op_t MD_DIVU  = md_op_t'(3);
    localparam md_op_t MD_MTHI  = md_op_t'(4);
    localparam md_op_t MD_MTLO  = md_op_t'(5);
`ifdef MD_MADD_EN
    localparam md_op_t MD_MADD  = md_op_t'(6);
    localparam md_op_t MD_MADDU = md_op_t'(7);
    localparam md_op_t MD_MSUB  = md_op_t'(8);
    localparam md_op_t MD_MSUBU = md_op_t'(9);
`endif

    // IDLE <=> counter is zero, RUN <=> a multi-cycle op is in flight.
    typedef enum logic {MD_IDLE, MD_RUN} md_state_e;

    // How the top should treat an accepted op.
    typedef enum logic [1:0] {MD_CLS_NONE, MD_CLS_MULT, MD_CLS_DIV, MD_CLS_MT} md_cls_e;

    function automatic md_cls_e md_op_class(md_op_t op);
        md_cls_e cls;
        cls = MD_CLS_NONE;
        case (op)
            MD_MULT, MD_MULTU: cls = MD_CLS_MULT;
            MD_DIV,  MD_DIVU:  cls = MD_CLS_DIV;
            MD_MTHI, MD_MTLO:  cls = MD_CLS_MT;
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: cls = MD_CLS_MULT;
`endif
            default:           cls = MD_CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// EX <-> md_unit request/response bundle.
// Handshake: EX (master) pulses start for one cycle with md_op/A/B valid;
// md_unit (slave) accepts only while busy is low, and a start seen while
// busy is high is dropped. HI/LO are always valid; state is a debug view.
interface md_unit_if;
    import md_unit_pkg::*;

    logic        start;
    md_op_t      md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    md_state_e   state;

    modport master (output start, md_op, A, B, input busy, HI, LO, state);
    modport slave  (input start, md_op, A, B, output busy, HI, LO, state);
endinterface

// File: rtl/md_unit_calc.sv
// md_calc: purely combinational result generator for md_unit. Produces the
// {HI,LO} an op would leave behind, including signed/unsigned products,
// division with the divide-by-zero and INT_MIN/-1 cases, MTHI/MTLO, and the
// accumulate ops when MD_MADD_EN is defined.
module md_calc
    import md_unit_pkg::*;
(
    input  md_op_t      md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] HI,
    input  logic [31:0] LO,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] quot_s, rem_s, quot_u, rem_u;
    logic        [63:0] res;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Division with the two cases a plain divider leaves undefined.
    always_comb begin
        quot_s = 32'hFFFF_FFFF;
        rem_s  = A;
        quot_u = 32'hFFFF_FFFF;
        rem_u  = A;
        if (B != 32'd0) begin
            quot_u = A / B;
            rem_u  = A % B;
            if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                quot_s = 32'h8000_0000;
                rem_s  = 32'd0;
            end else begin
                quot_s = $signed(A) / $signed(B);
                rem_s  = $signed(A) % $signed(B);
            end
        end
    end

    // Select the 64-bit {HI,LO} result for the requested op.
    always_comb begin
        res = {HI, LO};
        case (md_op)
            MD_MULT:  res = $unsigned(prod_s);
            MD_MULTU: res = prod_u;
            MD_DIV:   res = {rem_s, quot_s};
            MD_DIVU:  res = {rem_u, quot_u};
            MD_MTHI:  res = {A, LO};
            MD_MTLO:  res = {HI, A};
`ifdef MD_MADD_EN
            MD_MADD:  res = {HI, LO} + $unsigned(prod_s);
            MD_MADDU: res = {HI, LO} + prod_u;
            MD_MSUB:  res = {HI, LO} - $unsigned(prod_s);
            MD_MSUBU: res = {HI, LO} - prod_u;
`endif
            default:  res = {HI, LO};
        endcase
    end

    assign res_hi = res[63:32];
    assign res_lo = res[31:0];

endmodule

// File: rtl/md_unit.sv
// md_unit: multiply/divide responder owning architectural HI/LO.
// Results are computed at the accept edge, parked in pend registers and
// committed to HI/LO after a fixed MULT_LAT/DIV_LAT busy window, so the
// latency seen by the hazard unit never depends on the operands.
// Optional macro: MD_MADD_EN (adds MADD/MADDU/MSUB/MSUBU).
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_LAT = 5,   // legal 1..MD_LAT_MAX
    parameter int DIV_LAT  = 10   // legal 1..MD_LAT_MAX
) (
    input logic         clk,
    input logic         reset,
    md_unit_if.slave    bus
);

    md_state_e   state_q;
    md_cnt_t     cnt_q;
    logic        busy_q;
    logic [31:0] pend_hi_q, pend_lo_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] res_hi, res_lo;
    md_cls_e     cls;

    assign cls = md_op_class(bus.md_op);

    md_calc u_calc (
        .md_op  (bus.md_op),
        .A      (bus.A),
        .B      (bus.B),
        .HI     (hi_q),
        .LO     (lo_q),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // Accept in IDLE, count down in RUN, commit pend -> HI/LO on the 1->0 edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (bus.start) begin
                        case (cls)
                            MD_CLS_MULT: begin
                                pend_hi_q <= res_hi;
                                pend_lo_q <= res_lo;
                                cnt_q     <= md_cnt_t'(MULT_LAT);
                                busy_q    <= 1'b1;
                                state_q   <= MD_RUN;
                            end
                            MD_CLS_DIV: begin
                                pend_hi_q <= res_hi;
                                pend_lo_q <= res_lo;
                                cnt_q     <= md_cnt_t'(DIV_LAT);
                                busy_q    <= 1'b1;
                                state_q   <= MD_RUN;
                            end
                            MD_CLS_MT: begin
                                hi_q <= res_hi;
                                lo_q <= res_lo;
                            end
                            default: ;
                        endcase
                    end
                end
                MD_RUN: begin
                    // A start here is a hazard-unit bug; it is simply dropped.
                    cnt_q <= cnt_q - md_cnt_t'(1);
                    if (cnt_q == md_cnt_t'(1)) begin
                        hi_q    <= pend_hi_q;
                        lo_q    <= pend_lo_q;
                        busy_q  <= 1'b0;
                        state_q <= MD_IDLE;
                    end
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: a vector table of ops with known
// {HI,LO} results and busy lengths, a few random MULTU/DIVU vectors, and
// hand-written sequences for start-while-busy, reset mid-DIV and undefined op.
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic clk;
    logic reset;

    md_unit_if bus ();

    md_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    logic [63:0] cur;       // last committed {HI,LO} the bench believes in
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        md_op_t      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;   // {HI,LO}
        int          lat;   // busy cycles (0 for MTHI/MTLO)
        string       name;
    } vec_t;

    vec_t vecs[$];

    // ---------------- driver ----------------
    task automatic drive_start(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.A     = a;
        bus.B     = b;
    endtask

    task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input string name);
        int n;
        logic [63:0] got;
        @(negedge clk);
        drive_start(op, a, b);
        exp_q.push_back(exp);
        @(negedge clk);
        bus.start = 1'b0;
        if (lat > 0) check({name, "_hold"}, {bus.HI, bus.LO}, cur);
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 64'(n), 64'(lat));
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            got = exp_q.pop_front();
            check(name, {bus.HI, bus.LO}, got);
            cur = got;
        end
    endtask

    // ---------------- test ----------------
    initial begin
        int n;
        logic [31:0] ra, rb;
        logic [63:0] e;

        vecs.push_back('{MD_MULT,  32'hFFFF_FFFF, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFE}, MULT_LAT, "mult_neg1x2"});
        vecs.push_back('{MD_MULTU, 32'hFFFF_FFFF, 32'd2,        {32'h0000_0001, 32'hFFFF_FFFE}, MULT_LAT, "multu_maxx2"});
        vecs.push_back('{MD_DIV,   32'hFFFF_FFF9, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, DIV_LAT,  "div_m7_2"});
        vecs.push_back('{MD_DIVU,  32'd7,         32'd0,        {32'h0000_0007, 32'hFFFF_FFFF}, DIV_LAT,  "divu_by0"});
        vecs.push_back('{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF,{32'h0000_0000, 32'h8000_0000}, DIV_LAT,  "div_ovf"});
        vecs.push_back('{MD_DIV,   32'd7,         32'd0,        {32'h0000_0007, 32'hFFFF_FFFF}, DIV_LAT,  "div_by0"});
        vecs.push_back('{MD_MTHI,  32'h1234_5678, 32'd0,        {32'h1234_5678, 32'hFFFF_FFFF}, 0,        "mthi"});
        vecs.push_back('{MD_MTLO,  32'hCAFE_F00D, 32'd0,        {32'h1234_5678, 32'hCAFE_F00D}, 0,        "mtlo"});
        vecs.push_back('{MD_DIV,   32'd7,         32'hFFFF_FFFE,{32'h0000_0001, 32'hFFFF_FFFD}, DIV_LAT,  "div_7_m2"});
        vecs.push_back('{MD_DIV,   32'hFFFF_FFF8, 32'd3,        {32'hFFFF_FFFE, 32'hFFFF_FFFE}, DIV_LAT,  "div_m8_3"});
        vecs.push_back('{MD_DIVU,  32'd100,       32'd7,        {32'h0000_0002, 32'h0000_000E}, DIV_LAT,  "divu_100_7"});
        vecs.push_back('{MD_MULT,  32'h8000_0000, 32'h8000_0000,{32'h4000_0000, 32'h0000_0000}, MULT_LAT, "mult_min_sq"});
        vecs.push_back('{MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF,{32'h0000_0000, 32'h0000_0001}, MULT_LAT, "mult_m1_sq"});
        vecs.push_back('{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,{32'hFFFF_FFFE, 32'h0000_0001}, MULT_LAT, "multu_max_sq"});
        vecs.push_back('{MD_MTHI,  32'h0000_0000, 32'd0,        {32'h0000_0000, 32'h0000_0001}, 0,        "mthi_zero"});
        vecs.push_back('{MD_MTLO,  32'hFFFF_FFFF, 32'd0,        {32'h0000_0000, 32'hFFFF_FFFF}, 0,        "mtlo_ones"});
`ifdef MD_MADD_EN
        vecs.push_back('{MD_MADDU, 32'd1,         32'd1,        {32'h0000_0001, 32'h0000_0000}, MULT_LAT, "maddu_carry"});
        vecs.push_back('{MD_MSUB,  32'd2,         32'd3,        {32'h0000_0000, 32'hFFFF_FFFA}, MULT_LAT, "msub_borrow"});
        vecs.push_back('{MD_MADD,  32'hFFFF_FFFF, 32'd1,        {32'h0000_0000, 32'hFFFF_FFF9}, MULT_LAT, "madd_neg"});
        vecs.push_back('{MD_MSUBU, 32'd1,         32'hFFFF_FFFF,{32'hFFFF_FFFF, 32'hFFFF_FFFA}, MULT_LAT, "msubu_wrap"});
`endif

        bus.start = 1'b0;
        bus.md_op = MD_MULT;
        bus.A     = '0;
        bus.B     = '0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_hilo", {bus.HI, bus.LO}, 64'd0);
        reset = 1'b0;
        cur   = 64'd0;

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);

        // Random unsigned multiply / divide against a bench model.
        for (int i = 0; i < 6; i++) begin
            ra = $urandom();
            rb = 32'($urandom_range(1, 100_000));
            if (i % 2 == 0) begin
                e = {32'd0, ra} * {32'd0, rb};
                run_op(MD_MULTU, ra, rb, e, MULT_LAT, "rand_multu");
            end else begin
                e = {ra % rb, ra / rb};
                run_op(MD_DIVU, ra, rb, e, DIV_LAT, "rand_divu");
            end
        end

        // Start arriving mid-DIV must be dropped; DIV still commits on time.
        @(negedge clk);
        drive_start(MD_DIVU, 32'd100, 32'd7);
        exp_q.push_back({32'd2, 32'd14});
        @(negedge clk);
        n = 0;
        while (bus.busy && n < 40) begin
            if (n == 2) drive_start(MD_MULT, 32'd3, 32'd3);
            else bus.start = 1'b0;
            n++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("busy_start_cycles", 64'(n), 64'(DIV_LAT));
        e = exp_q.pop_front();
        check("busy_start_result", {bus.HI, bus.LO}, e);
        cur = e;
        repeat (MULT_LAT + 2) @(negedge clk);
        check("busy_start_no_mult", {bus.HI, bus.LO}, cur);
        check("busy_start_idle", 64'(bus.busy), 64'd0);

        // Reset in the third busy cycle of a DIV discards it.
        @(negedge clk);
        drive_start(MD_DIV, 32'd50, 32'd3);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_busy", 64'(bus.busy), 64'd0);
        check("mid_reset_hilo", {bus.HI, bus.LO}, 64'd0);
        repeat (DIV_LAT + 3) @(negedge clk);
        check("no_late_write", {bus.HI, bus.LO}, 64'd0);
        cur = 64'd0;

        // Undefined encoding (all ones) is ignored.
        run_op(MD_MTHI, 32'hA5A5_0001, 32'd0, {32'hA5A5_0001, 32'd0}, 0, "mthi_pre_undef");
        @(negedge clk);
        drive_start('1, 32'hDEAD_BEEF, 32'd9);
        @(negedge clk);
        bus.start = 1'b0;
        check("undef_busy", 64'(bus.busy), 64'd0);
        repeat (DIV_LAT + 2) @(negedge clk);
        check("undef_hilo", {bus.HI, bus.LO}, cur);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide responder for the pipeline's EX stage; owns architectural HI/LO registers.
- EX issues one request per instruction (start + op + operands); md_unit returns busy and the HI/LO values.
- Hazard_Unit stalls any HI/LO-touching instruction in D while start or busy is high.
- Executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency, and MTHI/MTLO in one cycle.

Parameters:
- MULT_LAT, 5, busy cycles for MULT/MULTU (legal range 1..15).
- DIV_LAT, 10, busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe from EX; one cycle per instruction.
- md_op  input  3  operation code; encodings defined in macro.v.
- A  input  32  rs operand after EX forwarding.
- B  input  32  rt operand after EX forwarding.
- busy  output  1  registered; high while a multi-cycle operation is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset: busy=0, HI=0, LO=0, cnt=0, pending results=0. Takes effect at the next edge with reset high, regardless of any operation in flight; the in-flight operation is discarded.
- States: IDLE (cnt==0) and RUN (cnt!=0). busy is high exactly in RUN.
- Acceptance:
  - start is accepted only in IDLE.
  - start during RUN is ignored: no state change, no error. The hazard unit is responsible for never issuing one.
- MULT/MULTU:
  - On the accept edge, latch the 64-bit product (signed or unsigned) into pend_hi/pend_lo, load cnt=MULT_LAT, go to RUN.
- DIV/DIVU:
  - On the accept edge, latch LO=quotient and HI=remainder into pend registers, load cnt=DIV_LAT, go to RUN.
  - Signed division truncates toward zero; remainder takes the dividend's sign.
- Boundary cases:
  - Divide by zero (signed or unsigned): pend_lo=32'hFFFF_FFFF, pend_hi=A.
  - Signed 32'h8000_0000 / 32'hFFFF_FFFF: pend_lo=32'h8000_0000, pend_hi=0.
- RUN: cnt decrements each cycle. On the edge where cnt goes 1->0, HI<=pend_hi, LO<=pend_lo, busy<=0.
- Latency: start at edge t gives busy=1 for cycles t+1 .. t+LAT. The new HI/LO are visible and busy=0 from cycle t+LAT+1.
- MTHI/MTLO: accepted only in IDLE. HI (or LO) <= A at the accept edge; busy stays 0.
- Undefined md_op with start in IDLE: ignored.
- HI/LO hold their old values throughout RUN. MFHI/MFLO read them combinationally.

Optional Feature:
- Macro MD_MADD_EN.
- Defined:
  - Adds ops MADD, MADDU, MSUB, MSUBU (encodings in macro.v).
  - Result = {HI,LO} ± the 64-bit product of A and B (signed or unsigned product), modulo 2^64.
  - The current HI/LO are sampled at the accept edge.
  - Latency is MULT_LAT.
- Undefined: these encodings are treated as undefined ops and ignored. No accumulate logic is synthesized.

Decomposition:
- macro.v holds the md_op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, plus MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU under the macro.
- macro.v also holds the latency limit constant.
- One combinational sub-module, md_calc: inputs md_op, A, B, HI, LO; outputs res_hi, res_lo. Covers signedness, divide-by-zero, overflow and accumulate.
- md_unit keeps only the counter, the pend registers and HI/LO.

Test Plan:
- MULT A=32'hFFFF_FFFF, B=2 -> busy high for 5 cycles; then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFE.
- MULTU A=32'hFFFF_FFFF, B=2 -> HI=1, LO=32'hFFFF_FFFE.
- DIV A=-7, B=2 -> busy high for 10 cycles; then LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
- DIVU A=7, B=0 -> LO=32'hFFFF_FFFF, HI=7.
- DIV A=32'h8000_0000, B=-1 -> LO=32'h8000_0000, HI=0.
- MTHI A=32'h1234_5678 -> HI updated the next cycle, busy stays 0.
- start MULT during a DIV in flight -> ignored; DIV result written on schedule.
- reset at the 3rd busy cycle of a DIV -> busy=0, HI=0, LO=0 the next cycle; no late write.
- With MD_MADD_EN defined: HI=0, LO=32'hFFFF_FFFF, MADDU A=1, B=1 -> HI=1, LO=0.
